bus_arbiter: RTL and testbench

//  Two-master arbiter for the serial system bus. Takes approval requests from two

---
 rtl/bus_arbiter.sv | 143 ++++++++++++++
 tb/tb_bus_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
//   Two-master arbiter for the serial system bus. Grants the bus to one
//   master at a time, drives the bus-mux owner select, inserts a one-cycle
//   turnaround between owners, alternates owners when both are waiting, and
//   revokes a grant that has been held for TIMEOUT_CYCLES cycles.
//
// Parameters
//   TIMEOUT_CYCLES  maximum number of cycles a grant may stay high
//   CNT_WIDTH       hold-counter width; must represent TIMEOUT_CYCLES-1
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous, active-low reset
//   m1_request  level request from master 1, held until its transaction ends
//   m2_request  level request from master 2
//   m1_done     one-cycle pulse, master 1 transaction complete
//   m2_done     one-cycle pulse, master 2 transaction complete
//   m1_grant    grant to master 1 (registered)
//   m2_grant    grant to master 2 (registered)
//   m1_busy     bus owned by master 2, or in turnaround
//   m2_busy     bus owned by master 1, or in turnaround
//   bus_owner   mux select: 0 = master 1, 1 = master 2 (held between grants)
//   bus_active  high while either grant is high
//   timeout     one-cycle pulse when the watchdog revokes a grant
// ---------------------------------------------------------------------------
module bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = 11
) (
  input  logic clk,
  input  logic reset,
  input  logic m1_request,
  input  logic m2_request,
  input  logic m1_done,
  input  logic m2_done,
  output logic m1_grant,
  output logic m2_grant,
  output logic m1_busy,
  output logic m2_busy,
  output logic bus_owner,
  output logic bus_active,
  output logic timeout
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_GRANT_M1 = 2'd1;
  localparam logic [1:0] ST_GRANT_M2 = 2'd2;
  localparam logic [1:0] ST_RELEASE  = 2'd3;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [1:0]           state, state_nxt;
  logic [CNT_WIDTH-1:0] hold_cnt, hold_cnt_nxt;
  // Owner of the most recent grant, same encoding as bus_owner.
  logic                 last_owner, last_owner_nxt;
  logic                 timeout_nxt;

  logic owner_is_m2;
  logic owner_req;
  logic owner_done;
  logic pick_valid;
  logic pick_m2;

  // Arbitration decision, used from both IDLE and RELEASE. On a tie the
  // master that did not own the bus last wins.
  always_comb begin
    pick_valid = m1_request | m2_request;
    if (m1_request && m2_request) pick_m2 = ~last_owner;
    else                          pick_m2 = m2_request;
  end

  // NOTE: every signal written in this block gets a default first, so no
  // path through the case statement can leave one unassigned (no latches).
  always_comb begin
    state_nxt      = state;
    hold_cnt_nxt   = hold_cnt;
    last_owner_nxt = last_owner;
    timeout_nxt    = 1'b0;

    owner_is_m2 = (state == ST_GRANT_M2);
    owner_req   = owner_is_m2 ? m2_request : m1_request;
    owner_done  = owner_is_m2 ? m2_done    : m1_done;

    case (state)
      ST_GRANT_M1, ST_GRANT_M2: begin
        if (owner_done || !owner_req) begin
          // Voluntary end (done or withdrawal) takes precedence over the
          // watchdog, so no timeout pulse on a simultaneous expiry.
          state_nxt      = ST_RELEASE;
          last_owner_nxt = owner_is_m2;
        end else if (hold_cnt == CNT_MAX) begin
          state_nxt      = ST_RELEASE;
          last_owner_nxt = owner_is_m2;
          timeout_nxt    = 1'b1;
        end else begin
          hold_cnt_nxt = hold_cnt + CNT_WIDTH'(1);
        end
      end
      default: begin
        // IDLE and RELEASE arbitrate identically; RELEASE lasts one cycle.
        if (pick_valid) begin
          state_nxt    = pick_m2 ? ST_GRANT_M2 : ST_GRANT_M1;
          hold_cnt_nxt = '0;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
    endcase
  end

  // Outputs are registered from the next state so they change on the same
  // edge as the state itself.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      hold_cnt   <= '0;
      last_owner <= 1'b1;
      m1_grant   <= 1'b0;
      m2_grant   <= 1'b0;
      m1_busy    <= 1'b0;
      m2_busy    <= 1'b0;
      bus_owner  <= 1'b0;
      bus_active <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state      <= state_nxt;
      hold_cnt   <= hold_cnt_nxt;
      last_owner <= last_owner_nxt;
      m1_grant   <= (state_nxt == ST_GRANT_M1);
      m2_grant   <= (state_nxt == ST_GRANT_M2);
      m1_busy    <= (state_nxt == ST_GRANT_M2) || (state_nxt == ST_RELEASE);
      m2_busy    <= (state_nxt == ST_GRANT_M1) || (state_nxt == ST_RELEASE);
      bus_active <= (state_nxt == ST_GRANT_M1) || (state_nxt == ST_GRANT_M2);
      timeout    <= timeout_nxt;
      if (state_nxt == ST_GRANT_M2)      bus_owner <= 1'b1;
      else if (state_nxt == ST_GRANT_M1) bus_owner <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter
//   Self-checking bench for bus_arbiter (TIMEOUT_CYCLES = 16). A directed
//   vector table, hand-written watchdog / reset sequences and a randomized
//   phase, all compared against a cycle-level behavioural model.
// ---------------------------------------------------------------------------
module tb_bus_arbiter;

  localparam int TO = 16;

  logic clk = 1'b0;
  logic reset;
  logic m1_request, m2_request, m1_done, m2_done;
  logic m1_grant, m2_grant, m1_busy, m2_busy, bus_owner, bus_active, timeout;

  bus_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_WIDTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .m1_request (m1_request),
    .m2_request (m2_request),
    .m1_done    (m1_done),
    .m2_done    (m2_done),
    .m1_grant   (m1_grant),
    .m2_grant   (m2_grant),
    .m1_busy    (m1_busy),
    .m2_busy    (m2_busy),
    .bus_owner  (bus_owner),
    .bus_active (bus_active),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  // Output vector order: {m1_grant, m2_grant, m1_busy, m2_busy,
  //                       bus_owner, bus_active, timeout}
  logic [6:0] outs;
  assign outs = {m1_grant, m2_grant, m1_busy, m2_busy, bus_owner, bus_active, timeout};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // cur   : master holding the grant (0 = nobody)
  // gap   : turnaround cycle in progress
  // held  : number of cycles the current grant has been high
  // last  : master that held the most recent grant
  // owner : master the bus mux currently points at
  int cur, held, last, owner;
  bit gap, m_timeout;

  task automatic model_reset();
    cur = 0; gap = 0; held = 0; last = 2; owner = 1; m_timeout = 0;
  endtask

  task automatic model_edge();
    bit d, r;
    m_timeout = 0;
    if (cur != 0) begin
      d = (cur == 1) ? m1_done    : m2_done;
      r = (cur == 1) ? m1_request : m2_request;
      if (d || !r || held >= TO) begin
        m_timeout = !(d || !r);
        last = cur;
        cur  = 0;
        gap  = 1;
      end else begin
        held++;
      end
    end else begin
      gap = 0;
      if (m1_request && m2_request) cur = (last == 1) ? 2 : 1;
      else if (m1_request)          cur = 1;
      else if (m2_request)          cur = 2;
      if (cur != 0) begin
        held  = 1;
        owner = cur;
      end
    end
  endtask

  function automatic logic [6:0] model_outs();
    return {cur == 1, cur == 2, (cur == 2) || gap, (cur == 1) || gap,
            owner == 2, cur != 0, m_timeout};
  endfunction

  // One clock: DUT and model both see the edge, outputs compared on the
  // falling edge.
  task automatic step(input string name);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check(name, 32'(outs), 32'(model_outs()));
    check("grant_exclusive", 32'(m1_grant & m2_grant), 32'd0);
  endtask

  task automatic set_in(input logic r1, input logic r2, input logic d1, input logic d2);
    m1_request = r1; m2_request = r2; m1_done = d1; m2_done = d2;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct packed {
    logic       r1, r2, d1, d2;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[15];
  int   hi;

  initial begin
    //               r1    r2    d1    d2    g1g2b1b2 own act to
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 7'b0000_000};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 7'b1001_010};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 7'b1001_010};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 7'b0011_000};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 7'b0110_110};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 7'b0110_110};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 7'b0011_100};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 7'b1001_010};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 7'b0011_000};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 7'b0000_000};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 7'b0110_110};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 7'b0011_100};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 7'b0110_110};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 7'b0011_100};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 7'b0000_100};

    // Reset held low for three cycles.
    reset = 1'b0;
    set_in(0, 0, 0, 0);
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'(outs), 32'd0);
    reset = 1'b1;
    step("idle_after_reset");

    // Directed table.
    foreach (vecs[i]) begin
      set_in(vecs[i].r1, vecs[i].r2, vecs[i].d1, vecs[i].d2);
      step($sformatf("vec%0d_model", i));
      check($sformatf("vec%0d_table", i), 32'(outs), 32'(vecs[i].exp));
    end

    // Watchdog: m2 holds the bus without done, m1 waiting.
    set_in(0, 1, 0, 0);
    step("wd_grant_m2");
    set_in(1, 1, 0, 0);
    hi = m2_grant ? 1 : 0;
    for (int c = 0; c < 40 && m2_grant; c++) begin
      step("wd_hold");
      if (m2_grant) hi++;
    end
    check("wd_grant_cycles", 32'(hi), 32'(TO));
    check("wd_timeout_pulse", 32'({timeout, m2_grant, m1_busy, m2_busy}), 32'b1011);
    step("wd_m1_next");
    check("wd_m1_granted", 32'({m1_grant, timeout}), 32'b10);

    // Done lands on the same cycle the watchdog would expire: no pulse.
    for (int c = 1; c < TO; c++) step("wd_tie_hold");
    check("wd_tie_still_granted", 32'(m1_grant), 32'd1);
    set_in(1, 1, 1, 0);
    step("wd_tie_release");
    check("wd_tie_no_timeout", 32'({timeout, m1_grant}), 32'b00);
    set_in(1, 1, 0, 0);
    step("wd_tie_m2_next");

    // Asynchronous reset mid-grant, then arbitration restarts from IDLE.
    set_in(1, 0, 0, 1);
    step("ar_release_m2");
    step("ar_grant_m1");
    step("ar_hold_m1");
    check("ar_pre_grant", 32'(m1_grant), 32'd1);
    #2 reset = 1'b0;
    #1 check("ar_async_drop", 32'({m1_grant, bus_active, m2_busy}), 32'd0);
    model_reset();
    set_in(1, 1, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    step("ar_restart_m1_first");

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) m1_request = ~m1_request;
      if ($urandom_range(0, 5) == 0) m2_request = ~m2_request;
      m1_done = ($urandom_range(0, 7) == 0);
      m2_done = ($urandom_range(0, 7) == 0);
      step("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
